// File: rtl/seven_seg_mux.sv
// N-digit multiplexed seven-segment driver with frame-synchronous update, PWM brightness and output polarity.
// Define SEVEN_SEG_LZB_EN to enable leading-zero blanking.
module seven_seg_mux #(
    parameter int DIGITS         = 4,
    parameter int DIV            = 4000,
    parameter int BRIGHT_W       = 3,
    parameter bit EN_ACTIVE_LOW  = 1'b0,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   in_num,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [DIGITS-1:0]     enpos,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int PCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int KW  = $clog2(DIGITS);
    localparam int unsigned STEP = DIV >> BRIGHT_W;
    localparam logic [DIGITS-1:0] EN_MASK  = {DIGITS{EN_ACTIVE_LOW}};
    localparam logic [7:0]        SEG_MASK = {8{SEG_ACTIVE_LOW}};

    logic [PCW-1:0]       pc;
    logic [KW-1:0]        k;
    logic [4*DIGITS-1:0]  pend_num;
    logic [4*DIGITS-1:0]  disp_num;
    logic [DIGITS-1:0]    pend_dp;
    logic [DIGITS-1:0]    disp_dp;
    logic                 pend_v;
    logic                 run_q;
    logic [DIGITS-1:0]    enpos_q;
    logic [7:0]           seg_q;
    logic                 frame_q;

    logic                 pc_last;
    logic                 k_last;
    logic                 boundary;
    logic [3:0]           nib;
    logic [6:0]           glyph;
    logic                 dp_bit;
    logic [31:0]          thr;
    logic                 lit;
    logic                 blank;
    logic [DIGITS-1:0]    en_nxt;

    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        return g;
    endfunction

    assign pc_last  = (pc == PCW'(DIV - 1));
    assign k_last   = (k == KW'(DIGITS - 1));
    assign boundary = pc_last && k_last;

`ifdef SEVEN_SEG_LZB_EN
    logic [DIGITS-1:0] lz;
    logic              zero_run;

    // lz[i] is set when digits i..DIGITS-1 carry neither a non-zero nibble nor a dp
    always_comb begin
        zero_run = 1'b1;
        lz       = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run & (disp_num[4*i +: 4] == 4'd0) & ~disp_dp[i];
            lz[i]    = zero_run;
        end
    end

    assign blank = lz[k] & (k != '0);
`else
    assign blank = 1'b0;
`endif

    always_comb begin
        nib    = disp_num[{k, 2'b00} +: 4];
        glyph  = hex_glyph(nib);
        dp_bit = disp_dp[k];
        thr    = (32'(brightness) + 32'd1) * STEP;
        // pc=0 stays dark so segments settle before the enable rises
        lit    = (pc != '0) && (32'(pc) < thr) && !blank;
        en_nxt = lit ? (DIGITS'(1) << k) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            k        <= '0;
            pend_num <= '0;
            pend_dp  <= '0;
            pend_v   <= 1'b0;
            disp_num <= '0;
            disp_dp  <= '0;
            run_q    <= 1'b0;
            frame_q  <= 1'b0;
            enpos_q  <= EN_MASK;
            seg_q    <= SEG_MASK;
        end else begin
            run_q   <= 1'b1;
            pc      <= pc_last ? '0 : pc + 1'b1;
            if (pc_last)
                k <= k_last ? '0 : k + 1'b1;
            frame_q <= boundary;

            // a load on the boundary bypasses the pending stage entirely
            if (load && boundary) begin
                disp_num <= in_num;
                disp_dp  <= dp_in;
                pend_v   <= 1'b0;
            end else begin
                if (boundary && pend_v) begin
                    disp_num <= pend_num;
                    disp_dp  <= pend_dp;
                    pend_v   <= 1'b0;
                end
                if (load) begin
                    pend_num <= in_num;
                    pend_dp  <= dp_in;
                    pend_v   <= 1'b1;
                end
            end

            enpos_q <= en_nxt ^ EN_MASK;
            // first cycle out of reset still blank: run_q not yet set
            seg_q   <= (run_q ? {dp_bit, glyph} : 8'h00) ^ SEG_MASK;
        end
    end

    assign enpos      = enpos_q;
    assign seg        = seg_q;
    assign frame_done = frame_q;

endmodule
